// File: rtl/ffo_pkg.sv
// Shared types for the sequential find-first-one engine.
package ffo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/ffo_window_enc.sv
// Combinational STEP-bit priority encoder; offset is in the window's own 0..STEP-1 numbering.
module ffo_window_enc
    import ffo_pkg::*;
#(
    parameter int  STEP = 4,
    localparam int OW   = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic [0:STEP-1] w,
    input  logic            dir,
    output logic            any,
    output logic [OW-1:0]   off
);

    always_comb begin
        any = |w;
        off = '0;
        // Later matches overwrite earlier ones, so iterate opposite to the scan direction.
        if (dir == DIR_FWD) begin
            for (int i = STEP - 1; i >= 0; i--) begin
                if (w[i]) off = OW'(i);
            end
        end else begin
            for (int i = 0; i < STEP; i++) begin
                if (w[i]) off = OW'(i);
            end
        end
    end

endmodule

// File: rtl/ffo_scan_multi.sv
// Sequential find-first-one engine: scans a captured word STEP bits per cycle and
// reports the first (single mode) or every (all mode) set bit over a valid/ack handshake.
//
//   state  | meaning
//   IDLE   | ready, waiting for start
//   SCAN   | examining the window at cursor
//   REPORT | result held on v/p/last until out_ack
module ffo_scan_multi
    import ffo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [0:WIDTH-1] b,
    input  logic             dir,
    input  logic             find_all,
    input  logic             out_ack,
    output logic             ready,
    output logic             out_valid,
    output logic             v,
    output logic [PW-1:0]    p,
    output logic             last,
    output logic [PW:0]      count
);

    localparam int NW = WIDTH / STEP;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int OW = (STEP > 1) ? $clog2(STEP) : 1;

    state_t           state, state_nxt;
    logic [0:WIDTH-1] work;
    logic             dir_q;
    logic             all_q;
    logic [CW-1:0]    cursor;
    logic             v_q;
    logic [PW-1:0]    p_q;
    logic             last_q;
    logic [PW:0]      count_q;

    logic [CW-1:0]    win_idx;
    logic [PW-1:0]    base;
    logic [0:STEP-1]  win;
    logic             win_any;
    logic [OW-1:0]    win_off;
    logic [PW-1:0]    hit_p;
    logic             final_win;

    // cursor counts windows in scan order; reverse scans walk the word from the right
    assign win_idx   = (dir_q == DIR_REV) ? (CW'(NW - 1) - cursor) : cursor;
    assign base      = PW'(int'(win_idx) * STEP);
    assign win       = work[base +: STEP];
    assign hit_p     = base + PW'(win_off);
    assign final_win = (cursor == CW'(NW - 1));

    ffo_window_enc #(.STEP(STEP)) u_enc (
        .w   (win),
        .dir (dir_q),
        .any (win_any),
        .off (win_off)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (win_any || final_win) state_nxt = REPORT;
            REPORT:  if (out_ack) state_nxt = last_q ? IDLE : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        out_valid = (state == REPORT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            work    <= '0;
            dir_q   <= DIR_FWD;
            all_q   <= 1'b0;
            cursor  <= '0;
            v_q     <= 1'b0;
            p_q     <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work    <= b;
                        dir_q   <= dir;
                        all_q   <= find_all;
                        cursor  <= '0;
                        v_q     <= 1'b0;
                        p_q     <= '0;
                        last_q  <= 1'b0;
                        count_q <= '0;
                    end
                end
                SCAN: begin
                    if (win_any) begin
                        v_q    <= 1'b1;
                        p_q    <= hit_p;
                        last_q <= !all_q;
                    end else if (final_win) begin
                        v_q    <= 1'b0;
                        p_q    <= '0;
                        last_q <= 1'b1;
                    end else begin
                        cursor <= cursor + CW'(1);
                    end
                end
                REPORT: begin
                    if (out_ack) begin
                        if (v_q) count_q <= count_q + {{PW{1'b0}}, 1'b1};
                        // Clearing the reported bit lets the rescan of the same window find the next one.
                        if (!last_q) work[p_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign v     = v_q;
    assign p     = p_q;
    assign last  = last_q;
    assign count = count_q;

endmodule

// File: tb/tb_ffo_scan_multi.sv
// Self-checking bench for ffo_scan_multi: spec vector table, hand-written corner sequences,
// and randomized operations checked against a scan-order reference model.
module tb_ffo_scan_multi;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int NW = W / S;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [0:W-1]  b = '0;
    logic          dir = 1'b0;
    logic          find_all = 1'b0;
    logic          out_ack = 1'b0;
    logic          ready, out_valid, v, last;
    logic [4:0]    p;
    logic [5:0]    count;

    logic          start8 = 1'b0;
    logic [0:7]    b8 = '0;
    logic          dir8 = 1'b0;
    logic          all8 = 1'b0;
    logic          ack8 = 1'b0;
    logic          ready8, ov8, v8, last8;
    logic [2:0]    p8;
    logic [3:0]    count8;

    always #5 clock = ~clock;

    ffo_scan_multi #(.WIDTH(W), .STEP(S)) dut (
        .clock(clock), .reset(reset), .start(start), .b(b), .dir(dir),
        .find_all(find_all), .out_ack(out_ack), .ready(ready), .out_valid(out_valid),
        .v(v), .p(p), .last(last), .count(count)
    );

    ffo_scan_multi #(.WIDTH(8), .STEP(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .b(b8), .dir(dir8),
        .find_all(all8), .out_ack(ack8), .ready(ready8), .out_valid(ov8),
        .v(v8), .p(p8), .last(last8), .count(count8)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic v;
        int   p;
        logic last;
        int   win;
    } res_t;

    res_t exp_q[$];

    // Reference: walk bits in scan order; window number is scan position / STEP.
    task automatic build(input logic [0:W-1] bw, input logic d, input logic all);
        res_t r;
        exp_q.delete();
        for (int s = 0; s < W; s++) begin
            int idx;
            idx = d ? (W - 1 - s) : s;
            if (bw[idx] && (all || exp_q.size() == 0)) begin
                r.v = 1'b1; r.p = idx; r.last = !all; r.win = s / S;
                exp_q.push_back(r);
            end
        end
        if (all || exp_q.size() == 0) begin
            r.v = 1'b0; r.p = 0; r.last = 1'b1; r.win = NW - 1;
            exp_q.push_back(r);
        end
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [0:W-1] bw, input logic d, input logic all,
                          input int hold_max, output int first_p, output int first_edges,
                          output int final_count);
        res_t r;
        int   edges, cur, acks, hold;
        chk("ready_before_start", ready, 1);
        b = bw; dir = d; find_all = all; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        b = $urandom; dir = ~d; find_all = ~all;
        build(bw, d, all);
        cur = 0; acks = 0; first_p = -2; first_edges = -1;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            wait_valid(edges);
            if (first_edges < 0) begin
                first_edges = edges;
                first_p = v ? int'(p) : -1;
            end
            chk("result_latency", edges, 1 + r.win - cur);
            chk("result_v", v, r.v);
            if (r.v) chk("result_p", p, r.p);
            chk("result_last", last, r.last);
            hold = $urandom_range(hold_max, 0);
            repeat (hold) begin
                @(posedge clock); #1;
                chk("held_valid", out_valid, 1);
                chk("held_v", v, r.v);
            end
            out_ack = 1'b1;
            @(posedge clock); #1;
            out_ack = 1'b0;
            if (r.v) acks++;
            cur = r.win;
            chk("count_after_ack", count, acks);
        end
        chk("ready_after_op", ready, 1);
        final_count = int'(count);
    endtask

    typedef struct {
        logic [0:W-1] b;
        logic         d;
        logic         all;
        int           exp_p;
        int           exp_edges;
        int           exp_count;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int fp, fe, fc, edges;
        logic sv, sl;
        logic [4:0] sp;

        // b literals are written MSB-first, so b[i] is literal bit 31-i.
        tbl[0] = '{32'h0400_0000, 1'b0, 1'b0,  5, 2, 1};   // bit5, single
        tbl[1] = '{32'h0000_0000, 1'b0, 1'b0, -1, 8, 0};   // empty word
        tbl[2] = '{32'h3000_0002, 1'b0, 1'b1,  2, 1, 3};   // bits 2,3,30 forward, all
        tbl[3] = '{32'h3000_0002, 1'b1, 1'b1, 30, 1, 3};   // same, reverse
        tbl[4] = '{32'h0000_0001, 1'b1, 1'b0, 31, 1, 1};   // bit31 reverse
        tbl[5] = '{32'h8000_0001, 1'b1, 1'b1, 31, 1, 2};   // bits 0,31 reverse, all

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_v", v, 0);
        chk("rst_p", p, 0);
        chk("rst_last", last, 0);
        chk("rst_count", count, 0);
        chk("rst_ready8", ready8, 1);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].b, tbl[i].d, tbl[i].all, 2, fp, fe, fc);
            chk("tbl_first_p", fp, tbl[i].exp_p);
            chk("tbl_first_latency", fe, tbl[i].exp_edges);
            chk("tbl_final_count", fc, tbl[i].exp_count);
        end

        // Consumer stall with a stray start pulse.
        b = 32'h0400_0000; dir = 1'b0; find_all = 1'b0; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        wait_valid(edges);
        chk("stall_latency", edges, 2);
        sv = v; sp = p; sl = last;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            b = 32'hFFFF_FFFF;
            @(posedge clock); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_v", v, sv);
            chk("stall_p", p, sp);
            chk("stall_last", last, sl);
        end
        start = 1'b0;
        chk("stall_p_value", sp, 5);
        out_ack = 1'b1; @(posedge clock); #1; out_ack = 1'b0;
        chk("stall_ready", ready, 1);
        chk("stall_count", count, 1);
        @(posedge clock); #1;
        chk("stall_no_restart", out_valid, 0);
        chk("stall_still_idle", ready, 1);

        // out_ack while nothing is valid must be ignored.
        b = 32'h0000_0001; dir = 1'b0; find_all = 1'b0; start = 1'b1;
        @(posedge clock); #1; start = 1'b0; out_ack = 1'b1;
        repeat (4) @(posedge clock);
        #1 out_ack = 1'b0;
        wait_valid(edges);
        chk("early_ack_latency", edges + 4, 8);
        chk("early_ack_p", p, 31);
        chk("early_ack_count", count, 0);
        out_ack = 1'b1; @(posedge clock); #1; out_ack = 1'b0;
        chk("early_ack_final_count", count, 1);

        // Reset in the middle of a scan discards the operation.
        b = 32'h8000_0001; dir = 1'b0; find_all = 1'b1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        wait_valid(edges);
        chk("mid_first_p", p, 0);
        out_ack = 1'b1; @(posedge clock); #1; out_ack = 1'b0;
        chk("mid_count_before", count, 1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_count", count, 0);
        repeat (3) @(posedge clock);
        #1 chk("mid_rst_stays_idle", out_valid, 0);
        run_op(32'h0000_0001, 1'b0, 1'b0, 1, fp, fe, fc);
        chk("rerun_p", fp, 31);

        // Single-window configuration.
        b8 = 8'h01; dir8 = 1'b0; all8 = 1'b0; start8 = 1'b1;
        @(posedge clock); #1; start8 = 1'b0; b8 = 8'hFF;
        edges = 0;
        while (!ov8 && edges < 50) begin @(posedge clock); #1; edges++; end
        chk("w8_latency", edges, 1);
        chk("w8_v", v8, 1);
        chk("w8_p", p8, 7);
        chk("w8_last", last8, 1);
        ack8 = 1'b1; @(posedge clock); #1; ack8 = 1'b0;
        chk("w8_count", count8, 1);
        chk("w8_ready", ready8, 1);

        b8 = 8'h00; start8 = 1'b1;
        @(posedge clock); #1; start8 = 1'b0;
        edges = 0;
        while (!ov8 && edges < 50) begin @(posedge clock); #1; edges++; end
        chk("w8_empty_latency", edges, 1);
        chk("w8_empty_v", v8, 0);
        chk("w8_empty_last", last8, 1);
        ack8 = 1'b1; @(posedge clock); #1; ack8 = 1'b0;

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [0:W-1] rb;
            rb = $urandom & $urandom & $urandom;
            if ($urandom_range(3, 0) == 0) rb = 32'h1 << $urandom_range(31, 0);
            if ($urandom_range(7, 0) == 0) rb = '0;
            run_op(rb, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 3, fp, fe, fc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
